// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NUM_REQ requesters.
// Optional request error decode enabled by defining ALU_ARB_ERR_CHK_EN.
module alu_req_arbiter #(
  parameter int WIDTH   = 4,
  parameter int NUM_REQ = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*WIDTH-1:0] req_a_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_b_i,
  input  logic [NUM_REQ*4-1:0]     req_option_i,
  input  logic [NUM_REQ*2-1:0]     req_mode_i,
  output logic [NUM_REQ-1:0]       rsp_valid_o,
  input  logic [NUM_REQ-1:0]       rsp_ready_i,
  output logic [WIDTH-1:0]         rsp_data_o,
  output logic                     rsp_cout_o,
  output logic                     rsp_err_o,
  output logic                     busy_o,
  output logic [WIDTH-1:0]         alu_operand_a_o,
  output logic [WIDTH-1:0]         alu_operand_b_o,
  output logic [3:0]               alu_option_o,
  output logic [1:0]               alu_mode_sel_o,
  input  logic [WIDTH-1:0]         alu_data_i,
  input  logic                     alu_cout_i
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       opt_q, opt_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             cout_q, cout_d;
  logic             err_q, err_d;

  logic             gnt_vld;
  logic [IW-1:0]    gnt_idx;
  logic [IW-1:0]    cand;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [3:0]       sel_opt;
  logic [1:0]       sel_mode;
  logic             sel_err;

  // Search starts at the pointer and wraps, so the last owner goes last.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IW'((int'(ptr_q) + i) % NUM_REQ);
      if (!gnt_vld && req_valid_i[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign sel_a    = req_a_i[int'(gnt_idx)*WIDTH +: WIDTH];
  assign sel_b    = req_b_i[int'(gnt_idx)*WIDTH +: WIDTH];
  assign sel_opt  = req_option_i[int'(gnt_idx)*4 +: 4];
  assign sel_mode = req_mode_i[int'(gnt_idx)*2 +: 2];

`ifdef ALU_ARB_ERR_CHK_EN
  always_comb begin
    sel_err = 1'b0;
    unique case (sel_mode)
      2'b00: sel_err = (sel_opt > 4'd4) ||
                       (((sel_opt == 4'd3) || (sel_opt == 4'd4)) &&
                        (sel_b == '0));
      2'b01: sel_err = (sel_opt > 4'd7);
      2'b10: sel_err = (sel_opt > 4'd10);
      default: sel_err = 1'b1;
    endcase
  end
`else
  assign sel_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    a_d     = a_q;
    b_d     = b_q;
    opt_d   = opt_q;
    mode_d  = mode_q;
    data_d  = data_q;
    cout_d  = cout_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          owner_d = gnt_idx;
          if (gnt_idx == IW'(NUM_REQ - 1)) ptr_d = '0;
          else ptr_d = gnt_idx + IW'(1);
          if (sel_err) begin
            data_d  = '0;
            cout_d  = 1'b0;
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            a_d     = sel_a;
            b_d     = sel_b;
            opt_d   = sel_opt;
            mode_d  = sel_mode;
            err_d   = 1'b0;
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        data_d  = alu_data_i;
        cout_d  = alu_cout_i;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready_i[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      opt_q   <= '0;
      mode_q  <= '0;
      data_q  <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      a_q     <= a_d;
      b_q     <= b_d;
      opt_q   <= opt_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
    end
  end

  // Ready is gated by reset so it drops the moment reset asserts.
  always_comb begin
    req_ready_o = '0;
    if (rst_ni && (state_q == IDLE) && gnt_vld) req_ready_o[gnt_idx] = 1'b1;
  end

  always_comb begin
    rsp_valid_o = '0;
    if (state_q == RESP) rsp_valid_o[owner_q] = 1'b1;
  end

  assign rsp_data_o      = data_q;
  assign rsp_cout_o      = cout_q;
  assign rsp_err_o       = err_q;
  assign busy_o          = (state_q != IDLE);
  assign alu_operand_a_o = a_q;
  assign alu_operand_b_o = b_q;
  assign alu_option_o    = opt_q;
  assign alu_mode_sel_o  = mode_q;

endmodule
